alu_issue_ctrl: RTL and testbench

Upstream issue/capture stage for the clocked ALU (N-bit operands, 3-bit alu_op, N-bit alu_out, 16-bit z). Accepts one operation request through a valid/ready handshake and registers the operands and opcode onto the ALU inputs. It holds those inputs stable for the opcode's fixed latency, then captures alu_out/z into a response register presented through a second valid/ready handshake. It is the only driver of the ALU's in1/in2/alu_op.

---
 rtl/alu_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage for the clocked ALU: registers one request onto the ALU inputs and holds it
// for the opcode's latency, then presents the captured result. Optional ALU_ISSUE_STATS_EN adds counters.
module alu_issue_ctrl #(
  parameter int unsigned N         = 12,
  parameter int unsigned Z_W       = 16,
  parameter int unsigned SHORT_LAT = 1,
  parameter int unsigned LONG_LAT  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_op,
  input  logic [N-1:0]   req_a,
  input  logic [N-1:0]   req_b,
  output logic [N-1:0]   alu_in1,
  output logic [N-1:0]   alu_in2,
  output logic [2:0]     alu_op,
  input  logic [N-1:0]   alu_out,
  input  logic [Z_W-1:0] alu_z,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic [Z_W-1:0] rsp_z,
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0]    op_count,
  output logic [15:0]    long_op_count,
`endif
  output logic           busy
);

  // The counter holds the remaining wait edges, so it is loaded with latency minus one.
  localparam logic [3:0] ShortCnt = 4'(SHORT_LAT - 1);
  localparam logic [3:0] LongCnt  = 4'(LONG_LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [2:0]     op_q, op_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [N-1:0]   data_q, data_d;
  logic [Z_W-1:0] z_q, z_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    data_d      = data_q;
    z_d         = z_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          in1_d   = req_a;
          in2_d   = req_b;
          op_d    = req_op;
          cnt_d   = (req_op < 3'd3) ? ShortCnt : LongCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          data_d      = alu_out;
          z_d         = alu_z;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_d        = 3'd0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= 3'd0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
      z_q         <= z_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_z     = z_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_count_q, long_op_count_q;
  logic        hs;

  // alu_op still holds the opcode on the handshake edge; it clears on that same edge.
  assign hs = (state_q == StResp) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q      <= 16'd0;
      long_op_count_q <= 16'd0;
    end else if (hs) begin
      op_count_q <= op_count_q + 16'd1;
      if (op_q >= 3'd3) long_op_count_q <= long_op_count_q + 16'd1;
    end
  end

  assign op_count      = op_count_q;
  assign long_op_count = long_op_count_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, hand sequences and random ops checked
// against a transaction-level model with a summing ALU stub.
module tb_alu_issue_ctrl;

  localparam int N = 12;
  localparam int ZW = 16;
  localparam int SHORT_LAT = 1;
  localparam int LONG_LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [N-1:0]  req_a, req_b;
  logic [N-1:0]  alu_in1, alu_in2;
  logic [2:0]    alu_op;
  logic [N-1:0]  alu_out;
  logic [ZW-1:0] alu_z;
  logic          rsp_valid, rsp_ready;
  logic [N-1:0]  rsp_data;
  logic [ZW-1:0] rsp_z;
  logic          busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]   op_count, long_op_count;
`endif

  alu_issue_ctrl #(.N(N), .Z_W(ZW), .SHORT_LAT(SHORT_LAT), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_z(rsp_z),
`ifdef ALU_ISSUE_STATS_EN
    .op_count(op_count), .long_op_count(long_op_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stub: sum of operands; z tags opcode and in1 so swapped or stale inputs show up.
  assign alu_out = alu_in1 + alu_in2;
  assign alu_z   = {alu_op, alu_in1, 1'b0};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int prev_acc, prev_span;
  bit prev_ok = 0;
  int m_ops = 0, m_long = 0;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           hold;
    logic [N-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    return (op < 3) ? SHORT_LAT : LONG_LAT;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge right after the response handshake.
  task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int hold, input logic [N-1:0] exp, input bit noise);
    int lat;
    int acc;
    logic [ZW-1:0] exp_z;
    lat   = lat_of(op);
    exp_z = {op, a, 1'b0};
    check("idle_req_ready", req_ready, 1);
    check("idle_alu_op", alu_op, 0);
    check("idle_busy", busy, 0);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    acc = cyc;
    if (prev_ok) check("req_spacing", acc - prev_acc, prev_span);
    for (int j = 0; j < lat; j++) begin
      req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      req_a = 12'd99; req_b = 12'd99; req_op = 3'($urandom_range(0, 7));
      check("wait_in1", alu_in1, a);
      check("wait_in2", alu_in2, b);
      check("wait_op", alu_op, op);
      check("wait_req_ready", req_ready, 0);
      check("wait_busy", busy, 1);
      check("wait_rsp_valid", rsp_valid, 0);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, exp);
      check("rsp_z", rsp_z, exp_z);
      check("rsp_req_ready", req_ready, 0);
      rsp_ready = (h == hold);
      @(negedge clk);
    end
    req_valid = 0; rsp_ready = 0;
    m_ops++;
    if (op >= 3) m_long++;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_alu_op", alu_op, 0);
    check("post_in1_kept", alu_in1, a);
    check("post_busy", busy, 0);
`ifdef ALU_ISSUE_STATS_EN
    check("op_count", op_count, 32'(m_ops[15:0]));
    check("long_op_count", long_op_count, 32'(m_long[15:0]));
`endif
    prev_ok = 1; prev_acc = acc; prev_span = lat + hold + 2;
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0; rsp_ready = 0;
    rst = 1;
    #1;
    check("rst_in1", alu_in1, 0);
    check("rst_op", alu_op, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rel_req_ready", req_ready, 1);

    vecs.push_back('{3'd1, 12'd5, 12'd10, 0, 12'd15});
    vecs.push_back('{3'd3, 12'd5, 12'd10, 0, 12'd15});
    vecs.push_back('{3'd2, 12'd30, 12'd10, 5, 12'd40});
    vecs.push_back('{3'd0, 12'hFFF, 12'd1, 1, 12'd0});
    vecs.push_back('{3'd7, 12'd2048, 12'd2047, 2, 12'hFFF});
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp, i == 1);

    // Reset two cycles into a long op: everything clears at once, no response follows.
    req_valid = 1; req_op = 3'd5; req_a = 12'd7; req_b = 12'd8;
    @(negedge clk);
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rst = 1;
    #1;
    check("midrst_in1", alu_in1, 0);
    check("midrst_in2", alu_in2, 0);
    check("midrst_op", alu_op, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
`ifdef ALU_ISSUE_STATS_EN
    check("midrst_op_count", op_count, 0);
    m_ops = 0; m_long = 0;
`endif
    @(negedge clk);
    rst = 0; rsp_ready = 0;
    for (int k = 0; k < LONG_LAT + 1; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
    end
    prev_ok = 0;
    run_op(3'd4, 12'd4, 12'd20, 0, 12'd24, 0);

    // Back-to-back with immediate consumption: spacing lat+2 checked inside run_op.
    run_op(3'd1, 12'd4, 12'd20, 0, 12'd24, 0);
    run_op(3'd3, 12'd6, 12'd20, 0, 12'd26, 0);
    run_op(3'd1, 12'd1, 12'd1, 0, 12'd2, 0);

    for (int r = 0; r < 60; r++) begin
      logic [2:0] op;
      logic [N-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = N'($urandom);
      b  = N'($urandom);
      run_op(op, a, b, $urandom_range(0, 3), N'(32'(a) + 32'(b)), 1'($urandom_range(0, 1)));
    end

`ifdef ALU_ISSUE_STATS_EN
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    m_ops = 32'hFFFF;
    run_op(3'd1, 12'd3, 12'd3, 0, 12'd6, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
